// File: rtl/mem_master_pkg.sv
// Shared constants for the RAM initiator: FSM state encoding, default bus widths,
// and the read-buffer admission rule used when issuing read beats.
package mem_master_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_LEN_W  = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;

  // A read may be issued only if, after this edge's pop, the buffered plus
  // in-flight beats leave room for the word that lands one cycle later.
  function automatic logic buf_has_room(input logic [1:0] count,
                                        input logic       inflight,
                                        input logic       pop);
    logic [2:0] occ;
    occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    return occ < 3'd2;
  endfunction

endpackage

// File: rtl/mem_master_if.sv
// Command, write-stream, read-stream and RAM-side signals of the RAM initiator,
// seen from the initiator (master) and from its environment (slave).
interface mem_master_if
  import mem_master_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  logic              busy;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  mem_rdata,
    output cmd_ready, wr_ready,
    output rd_valid, rd_data, rd_last,
    output busy,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    output mem_rdata,
    input  cmd_ready, wr_ready,
    input  rd_valid, rd_data, rd_last,
    input  busy,
    input  mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_master_rd_skid_buf.sv
// Two-entry FIFO of {last, data} between the RAM read port and the read stream;
// a push and a pop in the same cycle are both honoured.
module mem_master_rd_skid_buf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_last_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] data_q [2];
  logic              last_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  // NOTE: the storage is reset too, because the head drives rd_data directly
  // and rd_data must read zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        data_q[wr_ptr_q] <= push_data_i;
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data_o = data_q[rd_ptr_q];
  assign head_last_o = last_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/mem_master.sv
// RAM initiator: accepts single/burst commands, drives registered RAM controls,
// and returns read beats through a 2-entry skid buffer under valid/ready.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input logic          clk,
  input logic          rst,
  mem_master_if.master bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W:0]    BEAT_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t            state_q,         state_d;
  logic [ADDR_W-1:0] addr_q,          addr_d;
  logic [LEN_W:0]    beats_q,         beats_d;
  logic              mem_we_q,        mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,      mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,     mem_wdata_d;
  logic              inflight_q,      inflight_d;
  logic              inflight_last_q, inflight_last_d;

  logic [DATA_W-1:0] head_data;
  logic              head_last;
  logic [1:0]        buf_count;
  logic              rd_valid;
  logic              pop;
  logic              issue;

  // A word issued at one edge is captured by the RAM on the negedge and
  // is pushed here, tagged with its last flag, at the following edge.
  mem_master_rd_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (bus.mem_rdata),
    .push_last_i (inflight_last_q),
    .pop_i       (pop),
    .head_data_o (head_data),
    .head_last_o (head_last),
    .count_o     (buf_count)
  );

  assign rd_valid = (buf_count != 2'd0);
  assign pop      = rd_valid & bus.rd_ready;
  assign issue    = (state_q == ST_READ) && (beats_q != '0) &&
                    buf_has_room(buf_count, inflight_q, pop);

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    beats_d         = beats_q;
    mem_we_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          beats_d = {1'b0, bus.cmd_len} + BEAT_ONE;
          state_d = bus.cmd_write ? ST_WRITE : ST_READ;
        end
      end

      ST_WRITE: begin
        if (bus.wr_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = bus.wr_data;
          addr_d      = addr_q + ADDR_ONE;
          beats_d     = beats_q - BEAT_ONE;
          if (beats_q == BEAT_ONE) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_READ: begin
        if (issue) begin
          mem_addr_d      = addr_q;
          addr_d          = addr_q + ADDR_ONE;
          beats_d         = beats_q - BEAT_ONE;
          inflight_d      = 1'b1;
          inflight_last_d = (beats_q == BEAT_ONE);
        end
        if (pop && head_last) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      beats_q         <= '0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      beats_q         <= beats_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.wr_ready  = (state_q == ST_WRITE);
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = head_data;
  assign bus.rd_last   = head_last;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a negedge-registered RAM model; each
// comparison is an immediate assertion against a hand-derived value.
module tb_mem_master;
  import mem_master_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  mem_master_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus ();

  mem_master #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM model: preloaded with addr ^ 0xC3C3, registers read data and
  // performs writes on the falling edge.
  logic [15:0] ram [65536];
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 16'(i) ^ 16'hC3C3;
    forever begin
      @(negedge clk);
      bus.mem_rdata = ram[bus.mem_addr];
      if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_wr_ready"},  32'(bus.wr_ready),  32'd0);
    check({tag, "_rd_valid"},  32'(bus.rd_valid),  32'd0);
    check({tag, "_rd_last"},   32'(bus.rd_last),   32'd0);
    check({tag, "_rd_data"},   32'(bus.rd_data),   32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [3:0] len);
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  logic [15:0] exp_rd   [8]  = '{16'hC2C3, 16'hC2C2, 16'hC2C1, 16'hC2C0,
                                 16'hC2C7, 16'hC2C6, 16'hC2C5, 16'hC2C4};
  logic [15:0] exp_addr [16] = '{16'h0100, 16'h0101, 16'h0102, 16'h0102,
                                 16'h0103, 16'h0103, 16'h0103, 16'h0103,
                                 16'h0103, 16'h0103, 16'h0103, 16'h0104,
                                 16'h0105, 16'h0106, 16'h0107, 16'h0107};
  logic [15:0] wrap_addr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic        gap       [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int          popped;
    int          issued;
    int          n;
    logic [15:0] prev_addr;
    logic        r;

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    rst = 1'b1;
    #3;
    check_reset_values("por");
    step();
    step();
    rst = 1'b0;

    // Single write then single read-back of 0x0003.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'h1234;
    send_cmd(1'b1, 16'h0003, 4'd0);
    check("t1_busy",      32'(bus.busy),      32'd1);
    check("t1_wr_ready",  32'(bus.wr_ready),  32'd1);
    check("t1_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("t1_we_idle",   32'(bus.mem_we),    32'd0);
    step();
    check("t1_we",    32'(bus.mem_we),    32'd1);
    check("t1_addr",  32'(bus.mem_addr),  32'h0003);
    check("t1_wdata", 32'(bus.mem_wdata), 32'h1234);
    check("t1_idle",  32'(bus.busy),      32'd0);
    bus.wr_valid = 1'b0;
    step();
    check("t1_we_off", 32'(bus.mem_we), 32'd0);

    send_cmd(1'b0, 16'h0003, 4'd0);
    check("t1r_valid_a1", 32'(bus.rd_valid), 32'd0);
    step();
    check("t1r_valid_a2", 32'(bus.rd_valid), 32'd0);
    check("t1r_addr",     32'(bus.mem_addr), 32'h0003);
    check("t1r_we",       32'(bus.mem_we),   32'd0);
    step();
    check("t1r_valid", 32'(bus.rd_valid), 32'd1);
    check("t1r_data",  32'(bus.rd_data),  32'h1234);
    check("t1r_last",  32'(bus.rd_last),  32'd1);
    bus.rd_ready = 1'b1;
    step();
    check("t1r_empty", 32'(bus.rd_valid), 32'd0);
    check("t1r_idle",  32'(bus.busy),     32'd0);

    // Burst write 0xA000..0xA003 at 0x0004, then full-rate read-back.
    bus.rd_ready = 1'b0;
    bus.wr_valid = 1'b1;
    send_cmd(1'b1, 16'h0004, 4'd3);
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = 16'hA000 + 16'(i);
      step();
      check($sformatf("t2w_we%0d", i),    32'(bus.mem_we),    32'd1);
      check($sformatf("t2w_addr%0d", i),  32'(bus.mem_addr),  32'h0004 + 32'(i));
      check($sformatf("t2w_wdata%0d", i), 32'(bus.mem_wdata), 32'hA000 + 32'(i));
    end
    check("t2w_idle", 32'(bus.busy), 32'd0);
    bus.wr_valid = 1'b0;
    step();
    check("t2w_we_off", 32'(bus.mem_we), 32'd0);

    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 16'h0004, 4'd3);
    step();
    check("t2r_lat", 32'(bus.rd_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t2r_valid%0d", i), 32'(bus.rd_valid), 32'd1);
      check($sformatf("t2r_data%0d", i),  32'(bus.rd_data),  32'hA000 + 32'(i));
      check($sformatf("t2r_last%0d", i),  32'(bus.rd_last),  32'(i == 3));
      check($sformatf("t2r_busy%0d", i),  32'(bus.busy),     32'd1);
    end
    step();
    check("t2r_idle",  32'(bus.busy),     32'd0);
    check("t2r_empty", 32'(bus.rd_valid), 32'd0);

    // Read len=7 at 0x0100 under backpressure: toggle, hold low, then drain.
    bus.rd_ready = 1'b0;
    send_cmd(1'b0, 16'h0100, 4'd7);
    popped    = 0;
    issued    = 0;
    prev_addr = bus.mem_addr;
    for (int k = 1; k <= 40 && popped < 8; k++) begin
      if (k <= 6)       r = (k % 2 == 1);
      else if (k <= 11) r = 1'b0;
      else              r = 1'b1;
      bus.rd_ready = r;
      if (bus.rd_valid && bus.rd_ready) begin
        check($sformatf("t3_data%0d", popped), 32'(bus.rd_data), 32'(exp_rd[popped]));
        check($sformatf("t3_last%0d", popped), 32'(bus.rd_last), 32'(popped == 7));
        popped++;
      end
      step();
      if (bus.mem_addr != prev_addr) issued++;
      prev_addr = bus.mem_addr;
      if (k <= 16) check($sformatf("t3_addr%0d", k), 32'(bus.mem_addr), 32'(exp_addr[k-1]));
      check($sformatf("t3_occ%0d", k), 32'((issued - popped) <= 2), 32'd1);
    end
    check("t3_beats",  32'(popped),   32'd8);
    check("t3_issued", 32'(issued),   32'd8);
    check("t3_idle",   32'(bus.busy), 32'd0);
    bus.rd_ready = 1'b0;

    // Write burst across the top of the address space.
    bus.wr_valid = 1'b1;
    send_cmd(1'b1, 16'hFFFE, 4'd3);
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = 16'h5000 + 16'(i);
      step();
      check($sformatf("t4_we%0d", i),   32'(bus.mem_we),   32'd1);
      check($sformatf("t4_addr%0d", i), 32'(bus.mem_addr), 32'(wrap_addr[i]));
    end
    check("t4_idle", 32'(bus.busy), 32'd0);
    bus.wr_valid = 1'b0;
    step();

    // Write burst with wr_valid gaps.
    send_cmd(1'b1, 16'h0020, 4'd3);
    n = 0;
    for (int j = 0; j < 7; j++) begin
      bus.wr_valid = gap[j];
      bus.wr_data  = 16'hB000 + 16'(n);
      step();
      check($sformatf("t5_we%0d", j), 32'(bus.mem_we), 32'(gap[j]));
      if (gap[j]) begin
        check($sformatf("t5_addr%0d", j),  32'(bus.mem_addr),  32'h0020 + 32'(n));
        check($sformatf("t5_wdata%0d", j), 32'(bus.mem_wdata), 32'hB000 + 32'(n));
        n++;
      end
      check($sformatf("t5_busy%0d", j), 32'(bus.busy), 32'(j < 6));
    end
    bus.wr_valid = 1'b0;
    step();
    check("t5_we_off",    32'(bus.mem_we),    32'd0);
    check("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Reset in the middle of a len=7 read, then an immediate new command.
    send_cmd(1'b0, 16'h0100, 4'd7);
    step();
    step();
    check("t6_pre_valid", 32'(bus.rd_valid), 32'd1);
    check("t6_pre_addr",  32'(bus.mem_addr), 32'h0101);
    rst = 1'b1;
    #1;
    check_reset_values("t6_rst");
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 16'h0040;
    bus.cmd_len   = 4'd0;
    bus.cmd_valid = 1'b1;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 16'h7777;
    step();
    check("t6_hold_busy",  32'(bus.busy),     32'd0);
    check("t6_hold_addr",  32'(bus.mem_addr), 32'd0);
    check("t6_hold_valid", 32'(bus.rd_valid), 32'd0);
    rst = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    check("t6_acc_busy",     32'(bus.busy),      32'd1);
    check("t6_acc_wr_ready", 32'(bus.wr_ready),  32'd1);
    check("t6_acc_cmd_rdy",  32'(bus.cmd_ready), 32'd0);
    step();
    check("t6_we",    32'(bus.mem_we),    32'd1);
    check("t6_addr",  32'(bus.mem_addr),  32'h0040);
    check("t6_wdata", 32'(bus.mem_wdata), 32'h7777);
    bus.wr_valid = 1'b0;
    step();
    check("t6_we_off", 32'(bus.mem_we), 32'd0);
    check("t6_idle",   32'(bus.busy),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
